imem_loader: RTL
================

# imem_loader

Boot-time writer for the 16-bit instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian byte pairs into 16-bit instruction words. Each word is written through the instruction memory write port at byte address 2·index, matching the PC's byte addressing and the memory's high/low byte split. The loader runs while the pipeline is held, then reports completion or error to the boot controller.

## Interface
- `MAX_WORDS`, default 101: instruction memory depth in words; larger counts are rejected.
- `ADDR_W`, default 16: width of `wr_addr`, matching the PC width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
- `in_valid`  in  1  stream byte present.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte; combinational from state.
- `wr_en`  out  1  one-cycle instruction memory write strobe.
- `wr_addr`  out  ADDR_W  byte address of the word, always even (2·index).
- `wr_data`  out  16  instruction word, `{high byte, low byte}`.
- `busy`  out  1  high from CNT_H through CHK.
- `done`  out  1  load succeeded; held until the next accepted `start` or `reset`.
- `err`  out  1  load failed; held until the next accepted `start` or `reset`.

## Operation
- Stream frame, in order:
  - count high byte, then count low byte (N, 16-bit);
  - 2·N data bytes, high byte of each word first;
  - one checksum byte, equal to the XOR of every preceding byte in the frame.
- A byte is accepted on a rising edge where `in_valid && in_ready`. No other byte is consumed.
- States and transitions:
  - IDLE: `in_ready`=0. An accepted `start` clears `done`, `err`, the word index and the running XOR, then moves to CNT_H.
  - CNT_H: accepted byte → N[15:8]; move to CNT_L.
  - CNT_L: accepted byte → N[7:0].
    - If N > MAX_WORDS → ERR.
    - Else if N == 0 → CHK.
    - Else → DAT_H.
  - DAT_H: accepted byte is latched as the high byte; move to DAT_L.
  - DAT_L: accepted byte completes the word and a write is issued; index increments.
    - If the index now equals N → CHK.
    - Else → DAT_H.
  - CHK: accepted byte is compared with the running XOR.
    - Equal → DONE, with `done`=1.
    - Not equal → ERR, with `err`=1.
  - DONE / ERR: `in_ready`=0. An accepted `start` restarts the load at CNT_H.
- The running XOR includes count and data bytes, but not the checksum byte itself.
- Words already written are never rolled back. A checksum error still leaves those words in memory.
- `start` in CNT_H..CHK is ignored.
- If `start` and an accepted byte occur in the same cycle, the byte takes effect and `start` is ignored.
- `reset` mid-load returns to IDLE immediately.
  - Partially received words are discarded.
  - Words already written remain in memory.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0; state = IDLE.
- `in_ready` is 1 in CNT_H, CNT_L, DAT_H, DAT_L and CHK, with no internal stall. The loader takes one byte per cycle when `in_valid` is held high.
- `wr_en`, `wr_addr` and `wr_data` are registered. They are asserted in the cycle after the low byte is accepted, for exactly one cycle. At other times `wr_addr` and `wr_data` hold their last values.
- Minimum frame time: 2 + 2N + 1 accepted cycles. The last `wr_en` happens in the same cycle the loader enters CHK.
- `done` / `err` rise in the cycle after the checksum byte is accepted.
- For an overflowing count, `err` rises in the cycle after the count low byte is accepted, with no write issued.
- `busy` falls in the same cycle that `done` or `err` rises.
- Gaps in `in_valid` stall the FSM with all state held; no timeout.

## Test plan
- Nominal load, stream 00 02 1A 32 30 05 1F:
  - `wr_en` at addr 0x0000 with 0x1A32, then at addr 0x0002 with 0x3005;
  - then `done`=1, `err`=0.
- Bad checksum, same frame with last byte 00:
  - both writes still occur;
  - `err`=1, `done`=0.
- Count overflow, stream 00 66 (N=102):
  - `err`=1 one cycle after the second byte;
  - no `wr_en`; `in_ready`=0 afterwards.
- Zero count, stream 00 00 00:
  - no writes; `done`=1.
- Backpressure and jitter:
  - nominal frame with random `in_valid` gaps gives identical writes and results;
  - `start` pulsed mid-frame has no effect.
- Reset mid-load:
  - assert `reset` after byte 1A of the nominal frame;
  - all outputs return to 0 and the state is IDLE;
  - a fresh `start` plus the nominal frame loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a framed byte stream (count, big-endian
// word pairs, XOR checksum) and issues one registered 16-bit write per assembled word.
module imem_loader #(
  parameter int MAX_WORDS = 101,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_CHK, S_DONE, S_ERR
  } state_e;

  localparam logic [15:0] MaxWords = 16'(MAX_WORDS);

  state_e              state_q,   state_d;
  logic [15:0]         count_q,   count_d;
  logic [15:0]         idx_q,     idx_d;
  logic [7:0]          xor_q,     xor_d;
  logic [7:0]          hi_q,      hi_d;
  logic                wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                done_q,    done_d;
  logic                err_q,     err_d;

  logic        accept;
  logic [15:0] n_full;
  logic [15:0] idx_inc;

  assign in_ready = state_q inside {S_CNT_H, S_CNT_L, S_DAT_H, S_DAT_L, S_CHK};
  assign busy     = in_ready;
  assign accept   = in_valid && in_ready;
  assign n_full   = {count_q[15:8], in_byte};
  assign idx_inc  = idx_q + 16'd1;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;

    // Bytes are never accepted in IDLE/DONE/ERR, so start cannot collide with a byte.
    if (state_q inside {S_IDLE, S_DONE, S_ERR}) begin
      if (start) begin
        state_d = S_CNT_H;
        done_d  = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        xor_d   = '0;
      end
    end else if (accept) begin
      if (state_q != S_CHK) xor_d = xor_q ^ in_byte;
      case (state_q)
        S_CNT_H: begin
          count_d = {in_byte, 8'h00};
          state_d = S_CNT_L;
        end
        S_CNT_L: begin
          count_d = n_full;
          if (n_full > MaxWords) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_H;
          end
        end
        S_DAT_H: begin
          hi_d    = in_byte;
          state_d = S_DAT_L;
        end
        S_DAT_L: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'({idx_q, 1'b0});
          wr_data_d = {hi_q, in_byte};
          idx_d     = idx_inc;
          state_d   = (idx_inc == count_q) ? S_CHK : S_DAT_H;
        end
        S_CHK: begin
          if (in_byte == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      hi_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
